// File: rtl/axi_wr_arbiter.sv
// Two-requester AXI write arbiter: round-robin AW grant one cycle after request; W and B are combinational pass-through.
// Backpressure: requester ready mirrors downstream ready for the granted/B-head requester; AW stalls while MAX_OUTST bursts await B.

// Generic power-of-two FIFO; read data is the head entry, valid while !empty.
module fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0]               wr_ptr;
  logic [PW-1:0]               rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign pop_dat = mem[rd_ptr];
  assign empty   = (count == '0);
endmodule

module axi_wr_arbiter #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 42,
  parameter int MAX_OUTST  = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic [1:0]                 i_awvalid,
  output logic [1:0]                 o_awready,
  input  logic [1:0][ADDR_WIDTH-1:0] i_awaddr,
  input  logic [1:0][7:0]            i_awlen,
  input  logic [1:0]                 i_wvalid,
  output logic [1:0]                 o_wready,
  input  logic [1:0][DATA_WIDTH-1:0] i_wdata,
  input  logic [1:0]                 i_wlast,
  output logic [1:0]                 o_bvalid,
  input  logic [1:0]                 i_bready,
  output logic [1:0][1:0]            o_bresp,
  output logic                       o_awvalid,
  input  logic                       i_awready,
  output logic [ADDR_WIDTH-1:0]      o_awaddr,
  output logic [7:0]                 o_awlen,
  output logic                       o_awid,
  output logic                       o_wvalid,
  input  logic                       i_wready,
  output logic [DATA_WIDTH-1:0]      o_wdata,
  output logic                       o_wlast,
  input  logic                       i_bvalid,
  output logic                       o_bready,
  input  logic [1:0]                 i_bresp
);
  localparam int CW = $clog2(MAX_OUTST) + 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t          state;
  state_t          state_nxt;
  logic            grant;
  logic            grant_nxt;
  logic            ptr;
  logic            ptr_nxt;
  logic            rst_n_sync;
  logic            aw_hs;
  logic            w_last_hs;
  logic            b_hs;
  logic            head;
  logic            fifo_empty;
  logic [CW-1:0]   outst_cnt;

  // Assert immediately, release on the next clock edge.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) rst_n_sync <= 1'b0;
    else            rst_n_sync <= 1'b1;
  end

  assign aw_hs     = (state == ADDR) && i_awready;
  assign w_last_hs = (state == DATA) && i_wvalid[grant] && i_wready && i_wlast[grant];
  assign b_hs      = !fifo_empty && i_bvalid && i_bready[head];

  // The B-route FIFO occupancy is the outstanding-burst count.
  fifo #(.WIDTH(1), .DEPTH(MAX_OUTST)) u_broute (
    .clk      (i_clk),
    .rst_n    (rst_n_sync),
    .push     (aw_hs),
    .push_dat (grant),
    .pop      (b_hs),
    .pop_dat  (head),
    .empty    (fifo_empty),
    .count    (outst_cnt)
  );

  always_ff @(posedge i_clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      state <= IDLE;
      grant <= 1'b0;
      ptr   <= 1'b0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (|i_awvalid && (outst_cnt < CW'(MAX_OUTST))) begin
          grant_nxt = (&i_awvalid) ? ptr : i_awvalid[1];
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        if (aw_hs) begin
          ptr_nxt   = ~grant;
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (w_last_hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_awvalid = (state == ADDR);
    o_awaddr  = i_awaddr[grant];
    o_awlen   = i_awlen[grant];
    o_awid    = grant;
    o_awready = '0;
    if (state == ADDR) o_awready[grant] = i_awready;

    o_wvalid  = (state == DATA) && i_wvalid[grant];
    o_wdata   = i_wdata[grant];
    o_wlast   = i_wlast[grant];
    o_wready  = '0;
    if (state == DATA) o_wready[grant] = i_wready;

    // Response code is broadcast; only the head requester sees valid.
    o_bresp   = {i_bresp, i_bresp};
    o_bvalid  = '0;
    o_bready  = 1'b0;
    if (!fifo_empty) begin
      o_bvalid[head] = i_bvalid;
      o_bready       = i_bready[head];
    end
  end
endmodule
